// File: rtl/uart_rx_fsm.sv
// UART receiver: 8N1 frames, mid-bit sampling, start-glitch rejection, framing-error detection.
// Optional even-parity bit and parity_err output when UART_RX_PARITY_EN is defined.
module uart_rx_fsm #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

    localparam logic [CNT_W-1:0] HALF_TGT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_TGT = CNT_W'(CLKS_PER_BIT - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       shift, shift_nxt;
    logic [7:0]       data_out_nxt;
    logic             data_valid_nxt, frame_err_nxt;
    logic             rx_meta, rx_s;
`ifdef UART_RX_PARITY_EN
    logic             par, par_nxt;
    logic             parity_err_nxt;
`endif

    // Both synchronizer stages reset high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments give every flop the pre-edge value of its source,
            // so rx_s is really two stages behind rx regardless of statement order.
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par        <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bit_idx    <= bit_idx_nxt;
            shift      <= shift_nxt;
            data_out   <= data_out_nxt;
            data_valid <= data_valid_nxt;
            frame_err  <= frame_err_nxt;
`ifdef UART_RX_PARITY_EN
            par        <= par_nxt;
            parity_err <= parity_err_nxt;
`endif
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that skipped
        // an assignment would otherwise infer a latch.
        state_nxt      = state;
        cnt_nxt        = cnt + CNT_W'(1);
        bit_idx_nxt    = bit_idx;
        shift_nxt      = shift;
        data_out_nxt   = data_out;
        data_valid_nxt = 1'b0;
        frame_err_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_nxt        = par;
        parity_err_nxt = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!rx_s) state_nxt = START;
            end
            START: begin
                if (cnt == HALF_TGT) begin
                    cnt_nxt     = '0;
                    bit_idx_nxt = '0;
                    state_nxt   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == FULL_TGT) begin
                    cnt_nxt            = '0;
                    shift_nxt[bit_idx] = rx_s;
                    bit_idx_nxt        = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == FULL_TGT) begin
                    cnt_nxt   = '0;
                    par_nxt   = rx_s;
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt == FULL_TGT) begin
                    cnt_nxt = '0;
                    // A low stop bit wins over any parity outcome.
                    if (!rx_s) begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = BREAK;
                    end else begin
                        state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (^{shift, par}) begin
                            parity_err_nxt = 1'b1;
                        end else begin
                            data_out_nxt   = shift;
                            data_valid_nxt = 1'b1;
                        end
`else
                        data_out_nxt   = shift;
                        data_valid_nxt = 1'b1;
`endif
                    end
                end
            end
            BREAK: begin
                cnt_nxt = '0;
                if (rx_s) state_nxt = IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm: directed frames plus randomized traffic against a
// frame-level model that predicts each pulse kind, its byte and its latency from the line.
module tb_uart_rx_fsm;

    localparam int CPB     = 16;
    localparam int K_VALID = 0;
    localparam int K_FERR  = 1;
    localparam int K_PERR  = 2;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN  = 1'b1;
    localparam int LAT     = 171;
`else
    localparam bit PAR_EN  = 1'b0;
    localparam int LAT     = 155;
`endif

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         start;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int         cmp_cnt = 0;
    int         mis_cnt = 0;
    int         cyc = 0;
    bit         started = 1'b0;
    exp_t       q[$];
    logic [7:0] exp_data_out = 8'h00;
    int         valid_cnt = 0;
    int         ferr_cnt = 0;
    int         perr_cnt = 0;
    int         last_valid = 0;
    int         prev_valid = 0;

    uart_rx_fsm #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            mis_cnt++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Line drivers: all start and end just after a rising edge.
    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_good);
        exp_t e;
        e.start = cyc;
        e.data  = d;
        e.kind  = !stop_bit ? K_FERR : (PAR_EN && !par_good) ? K_PERR : K_VALID;
        q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ !par_good);
`endif
        drive_bit(stop_bit);
    endtask

    // Compare process: every pulse must match the oldest predicted frame outcome.
    always @(negedge clk) begin
        int   npulse;
        int   kind_seen;
        int   delta;
        logic pp;
        exp_t e;
        if (reset) begin
            q.delete();
            exp_data_out = 8'h00;
        end else if (started) begin
            pp = 1'b0;
`ifdef UART_RX_PARITY_EN
            pp = parity_err;
`endif
            npulse = int'(data_valid) + int'(frame_err) + int'(pp);
            if (data_valid) begin
                valid_cnt++;
                prev_valid = last_valid;
                last_valid = cyc;
            end
            if (frame_err) ferr_cnt++;
            if (pp) perr_cnt++;
            if (npulse != 0) begin
                check("pulse_exclusive", npulse, 1);
                kind_seen = data_valid ? K_VALID : frame_err ? K_FERR : K_PERR;
                if (q.size() == 0) begin
                    cmp_cnt++;
                    mis_cnt++;
                    $display("FAIL unexpected_pulse: got kind %0d, expected none (cycle %0d)", kind_seen, cyc);
                end else begin
                    e = q.pop_front();
                    delta = cyc - e.start;
                    check("pulse_kind", kind_seen, e.kind);
                    check("pulse_latency", (delta >= LAT - 1 && delta <= LAT + 1) ? LAT : delta, LAT);
                    if (e.kind == K_VALID) exp_data_out = e.data;
                end
            end else if (q.size() != 0 && cyc > q[0].start + LAT + 1) begin
                e = q.pop_front();
                cmp_cnt++;
                mis_cnt++;
                $display("FAIL missing_pulse: got none, expected kind %0d byte %0h (cycle %0d)", e.kind, e.data, cyc);
                if (e.kind == K_VALID) exp_data_out = e.data;
            end
            check("data_out", data_out, exp_data_out);
        end
    end

    initial begin
        int v0, f0, p0, r;
        rx    = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        started = 1'b1;
        @(negedge clk);
        check("rst_data_out", data_out, 8'h00);
        check("rst_data_valid", data_valid, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(posedge clk);
        #1;

        // Single good frame.
        send_frame(8'hA5, 1'b1, 1'b1);
        idle(30);
        check("a5_data_out", data_out, 8'hA5);
        check("a5_busy", busy, 1'b0);
        check("a5_no_ferr", ferr_cnt, 0);
        check("a5_valid_count", valid_cnt, 1);

        // Back-to-back frames, no idle gap.
        v0 = valid_cnt;
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        idle(30);
        check("b2b_valid_count", valid_cnt, v0 + 2);
        check("b2b_gap_160pm1", (last_valid - prev_valid >= 159 && last_valid - prev_valid <= 161), 1'b1);
        check("b2b_data_out", data_out, 8'hFF);

        // Short start glitch is rejected.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        rx = 1'b0;
        repeat (5) @(posedge clk);
        #1 rx = 1'b1;
        check("glitch_busy_during", busy, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        check("glitch_busy_after", busy, 1'b0);
        check("glitch_data_out", data_out, 8'hFF);
        check("glitch_no_valid", valid_cnt, v0);
        check("glitch_no_ferr", ferr_cnt, f0);

        // Framing error followed by a held-low break.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, 1'b1);
        rx = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("break_busy", busy, 1'b1);
        check("break_ferr_once", ferr_cnt, f0 + 1);
        check("break_no_valid", valid_cnt, v0);
        check("break_data_out", data_out, 8'hFF);
        idle(4);
        check("break_released", busy, 1'b0);
        send_frame(8'h81, 1'b1, 1'b1);
        idle(30);
        check("after_break_data", data_out, 8'h81);

        // Reset in the middle of the data bits of 0x55.
        v0 = valid_cnt;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        reset = 1'b1;
        rx    = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        idle(30);
        check("midrst_data_out", data_out, 8'h00);
        check("midrst_busy", busy, 1'b0);
        check("midrst_no_valid", valid_cnt, v0);
        send_frame(8'h55, 1'b1, 1'b1);
        idle(30);
        check("after_rst_data", data_out, 8'h55);

`ifdef UART_RX_PARITY_EN
        v0 = valid_cnt;
        p0 = perr_cnt;
        send_frame(8'h07, 1'b1, 1'b0);
        idle(30);
        check("par_bad_perr", perr_cnt, p0 + 1);
        check("par_bad_no_valid", valid_cnt, v0);
        check("par_bad_data_out", data_out, 8'h55);
        send_frame(8'h07, 1'b1, 1'b1);
        idle(30);
        check("par_good_valid", valid_cnt, v0 + 1);
        check("par_good_data", data_out, 8'h07);
`else
        p0 = perr_cnt;
        check("no_parity_pulses", p0, 0);
`endif

        // Randomized traffic: good frames, glitches and framing errors with breaks.
        for (int i = 0; i < 24; i++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                rx = 1'b0;
                repeat ($urandom_range(1, 6)) @(posedge clk);
                #1;
                idle(16);
            end else if (r == 1) begin
                send_frame(8'($urandom), 1'b0, 1'($urandom));
                rx = 1'b0;
                repeat ($urandom_range(0, 30)) @(posedge clk);
                #1;
                idle(int'($urandom_range(4, 10)));
            end else begin
                send_frame(8'($urandom), 1'b1, ($urandom_range(0, 3) != 0));
                idle(int'($urandom_range(0, 20)));
            end
        end

        idle(200);
        check("all_frames_resolved", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
        $finish;
    end

endmodule
